// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined Y86 execute ALU: op codes, condition-code
// bit positions, controller states and the condition-code reset value.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  localparam logic [2:0] CC_RESET = 3'b100;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per cycle.
// product_o includes the current partial term, so it is the full product while done_o is high.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start_i,
  input  logic [WIDTH-1:0]         a_i,
  input  logic [WIDTH-1:0]         b_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [2*WIDTH-1:0]       product_o,
  output logic [$clog2(WIDTH):0]   count_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CNT_W-1:0]   count_q;
  logic               busy_q;

  assign acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign done_o    = busy_q && (count_q == CNT_W'(WIDTH - 1));
  assign busy_o    = busy_q;
  assign product_o = acc_d;
  assign count_o   = count_q;

  // Control and accumulator: cleared by reset so an aborted multiply leaves no residue
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_q  <= 1'b0;
      acc_q   <= '0;
      count_q <= '0;
    end else if (start_i) begin
      busy_q  <= 1'b1;
      acc_q   <= '0;
      count_q <= '0;
    end else if (busy_q) begin
      acc_q   <= acc_d;
      count_q <= count_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

  // Operand shifters: reloaded on every start, so no reset is needed
  always_ff @(posedge clk) begin
    if (start_i) begin
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
    end else if (busy_q) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered Y86 execute ALU with valid/ready handshake, internal ZF/SF/OF register
// and an iterative multi-cycle multiply.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_fun,
  input  logic [WIDTH-1:0] aluA,
  input  logic [WIDTH-1:0] aluB,
  input  logic             set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] valE,
  output logic             err,
  output logic [2:0]       cc
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  alu_state_t       state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] valE_q;
  logic             err_q;
  logic [2:0]       cc_q;
  logic             mul_set_cc_q;

  logic [WIDTH-1:0]   res_d;
  logic               of_d;
  logic               illegal_d;
  logic               accept;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic               mul_last;
  logic [2*WIDTH-1:0] mul_prod;
  logic [CNT_W-1:0]   mul_cnt;

  function automatic logic [2:0] flags_f(input logic [WIDTH-1:0] r, input logic of);
    logic [2:0] f;
    f        = '0;
    f[CC_ZF] = (r == '0);
    f[CC_SF] = r[WIDTH-1];
    f[CC_OF] = of;
    return f;
  endfunction

  assign in_ready  = (state_q == S_IDLE) && !mul_busy && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (alu_fun == ALU_MUL);
  assign mul_last  = mul_done && (mul_cnt == CNT_W'(WIDTH - 1));

  assign out_valid = out_valid_q;
  assign valE      = valE_q;
  assign err       = err_q;
  assign cc        = cc_q;

  always_comb begin
    res_d     = '0;
    of_d      = 1'b0;
    illegal_d = 1'b0;
    case (alu_fun)
      ALU_ADD: begin
        res_d = aluA + aluB;
        of_d  = (aluA[WIDTH-1] == aluB[WIDTH-1]) && (res_d[WIDTH-1] != aluA[WIDTH-1]);
      end
      ALU_SUB: begin
        res_d = aluA - aluB;
        of_d  = (aluA[WIDTH-1] != aluB[WIDTH-1]) && (res_d[WIDTH-1] != aluA[WIDTH-1]);
      end
      ALU_AND: res_d = aluA & aluB;
      ALU_XOR: res_d = aluA ^ aluB;
      ALU_MUL: res_d = '0;
      default: illegal_d = 1'b1;
    endcase
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .reset_n   (reset_n),
    .start_i   (mul_start),
    .a_i       (aluA),
    .b_i       (aluB),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_prod),
    .count_o   (mul_cnt)
  );

  // Result/condition-code stage: a drain frees the slot unless the same edge reloads it
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      out_valid_q  <= 1'b0;
      valE_q       <= '0;
      err_q        <= 1'b0;
      cc_q         <= CC_RESET;
      mul_set_cc_q <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (alu_fun == ALU_MUL) begin
              state_q      <= S_MUL;
              mul_set_cc_q <= set_cc;
            end else begin
              valE_q      <= res_d;
              err_q       <= illegal_d;
              out_valid_q <= 1'b1;
              if (set_cc && !illegal_d) cc_q <= flags_f(res_d, of_d);
            end
          end
        end
        S_MUL: begin
          if (mul_last) begin
            valE_q      <= mul_prod[WIDTH-1:0];
            err_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_IDLE;
            if (mul_set_cc_q)
              cc_q <= flags_f(mul_prod[WIDTH-1:0], |mul_prod[2*WIDTH-1:WIDTH]);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe at WIDTH=64 with hand-computed expectations.
module tb_alu_pipe;

  localparam int W = 64;

  logic         clk;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   alu_fun;
  logic [W-1:0] aluA;
  logic [W-1:0] aluB;
  logic         set_cc;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] valE;
  logic         err;
  logic [2:0]   cc;

  int checks;
  int failures;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_fun   (alu_fun),
    .aluA      (aluA),
    .aluB      (aluB),
    .set_cc    (set_cc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .valE      (valE),
    .err       (err),
    .cc        (cc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sc);
    in_valid = 1'b1;
    alu_fun  = f;
    aluA     = a;
    aluB     = b;
    set_cc   = sc;
  endtask

  task automatic issue(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sc);
    drive(f, a, b, sc);
    tick();
    in_valid = 1'b0;
  endtask

  // Counts edges until out_valid rises, bounded so a stuck multiply still reaches the summary
  task automatic wait_result(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
  endtask

  int  n;
  logic saw_valid;

  initial begin
    checks    = 0;
    failures  = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    alu_fun   = 3'b000;
    aluA      = '0;
    aluB      = '0;
    set_cc    = 1'b0;
    out_ready = 1'b1;

    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_valE", valE, 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_cc", 64'(cc), 64'h4);
    reset_n = 1'b1;
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    issue(3'b000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    chk("add_ovf_valE", valE, 64'h8000_0000_0000_0000);
    chk("add_ovf_valid", 64'(out_valid), 64'd1);
    chk("add_ovf_cc", 64'(cc), 64'h3);

    issue(3'b001, 64'd5, 64'd5, 1'b0);
    chk("sub_valE", valE, 64'd0);
    chk("sub_cc_hold", 64'(cc), 64'h3);

    drive(3'b010, 64'hF0F0, 64'hFF00, 1'b0);
    tick();
    chk("b2b_and_valE", valE, 64'hF000);
    chk("b2b_and_valid", 64'(out_valid), 64'd1);
    drive(3'b011, 64'hF0F0, 64'hFF00, 1'b0);
    tick();
    chk("b2b_xor_valE", valE, 64'h0FF0);
    chk("b2b_xor_valid", 64'(out_valid), 64'd1);
    drive(3'b000, 64'd1, 64'd2, 1'b0);
    tick();
    chk("b2b_add_valE", valE, 64'd3);
    chk("b2b_add_valid", 64'(out_valid), 64'd1);

    drive(3'b000, 64'd10, 64'd20, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valE", valE, 64'd3);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bp_release_valE", valE, 64'd30);
    chk("bp_cc_hold", 64'(cc), 64'h3);
    tick();
    chk("drain_valid", 64'(out_valid), 64'd0);

    issue(3'b100, 64'h1_0000_0000, 64'h1_0000_0000, 1'b1);
    chk("mul_busy_in_ready", 64'(in_ready), 64'd0);
    chk("mul_valid_low", 64'(out_valid), 64'd0);
    wait_result(n);
    chk("mul_latency", 64'(n), 64'd64);
    chk("mul_big_valE", valE, 64'd0);
    chk("mul_big_cc", 64'(cc), 64'h5);
    chk("mul_big_err", 64'(err), 64'd0);

    issue(3'b100, 64'd3, 64'd7, 1'b1);
    wait_result(n);
    chk("mul_small_latency", 64'(n), 64'd64);
    chk("mul_small_valE", valE, 64'd21);
    chk("mul_small_cc", 64'(cc), 64'h0);

    issue(3'b110, 64'd9, 64'd9, 1'b1);
    chk("ill_valE", valE, 64'd0);
    chk("ill_err", 64'(err), 64'd1);
    chk("ill_cc", 64'(cc), 64'h0);

    issue(3'b100, 64'd3, 64'd7, 1'b1);
    for (int i = 0; i < 29; i++) tick();
    reset_n = 1'b0;
    tick();
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_cc", 64'(cc), 64'h4);
    reset_n = 1'b1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    issue(3'b000, 64'd2, 64'd2, 1'b0);
    chk("post_rst_add_valE", valE, 64'd4);
    chk("post_rst_add_valid", 64'(out_valid), 64'd1);
    chk("post_rst_add_err", 64'(err), 64'd0);

    saw_valid = 1'b0;
    tick();
    for (int i = 0; i < 70; i++) begin
      if (out_valid) saw_valid = 1'b1;
      tick();
    end
    chk("no_stale_mul", 64'(saw_valid), 64'd0);
    chk("final_cc", 64'(cc), 64'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, registered successor to the combinational Y86 execute ALU. It accepts one operation per cycle over a valid/ready handshake and returns a registered result. It holds the ZF/SF/OF condition-code register internally, updated under `set_cc`. It adds an iterative multi-cycle multiply. It sits in the execute stage between decode operand latches and the memory/writeback path; `cc` feeds the branch/cmov condition logic.

## Interface
- `WIDTH`, 64: operand/result width, ≥ 4, power of two.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  operation accepted when `in_valid && in_ready` at a rising edge.
- `alu_fun`  in  3  op code (see Operation).
- `aluA`, `aluB`  in  WIDTH  operands.
- `set_cc`  in  1  update `cc` from this op's result.
- `out_valid`  out  1  `valE` holds a result.
- `out_ready`  in  1  consumer takes result when `out_valid && out_ready`.
- `valE`  out  WIDTH  registered result.
- `err`  out  1  registered with `valE`; result came from an illegal op code.
- `cc`  out  3  {ZF, SF, OF} register.

## Operation
- Op codes:
  - 000 ADD: A+B.
  - 001 SUB: A−B.
  - 010 AND: A&B.
  - 011 XOR: A^B.
  - 100 MUL: unsigned A×B, low WIDTH bits.
  - 101–111 illegal: `valE`=0, `err`=1, `cc` never updated.
- All arithmetic is modulo 2^WIDTH; carry is discarded.
- Flags are computed from the WIDTH-bit result R:
  - ZF = (R==0).
  - SF = R[WIDTH-1].
  - OF for ADD: A and B have the same sign, and R's sign differs from it.
  - OF for SUB: A and B have different signs, and R's sign differs from A's.
  - OF for AND/XOR: 0.
  - OF for MUL: upper WIDTH bits of the full 2·WIDTH product are nonzero.
- States:
  - IDLE: the only state that accepts input. A single-cycle op loads `valE`/`err`, sets `out_valid`, and stays in IDLE. MUL latches the operands, `set_cc`, a cleared 2·WIDTH accumulator and count=0, then goes to MUL.
  - MUL: one multiplier bit per cycle (shift-add). After WIDTH iterations it loads `valE` and goes to IDLE. `in_ready`=0 throughout.
- `in_ready` = (state==IDLE) && (!out_valid || out_ready).
- When `out_valid` is set, `valE`/`err` stay stable until the result is taken.
- When `cc` updates: at the edge that loads `valE`, if the op's latched `set_cc`=1 and the op is legal. `cc` is not otherwise gated by the output handshake.
- Reset (`reset_n`=0 at an edge) has priority over everything and aborts any MUL in progress:
  - state=IDLE, `out_valid`=0, `valE`=0, `err`=0;
  - `cc`=3'b100 (ZF=1, SF=0, OF=0);
  - accumulator and count cleared.

## Timing
- Single-cycle op accepted at edge k: `valE`/`out_valid` are visible after edge k.
- Throughput is one op per cycle while `out_ready`=1.
- MUL accepted at edge k: iterations run on edges k+1 … k+WIDTH; `out_valid` rises after edge k+WIDTH. No new op is accepted before edge k+WIDTH+1.
- Output drained and new op accepted at the same edge: `out_valid` stays 1 with the new result; no bubble.
- MUL completion while the previous result is still undrained cannot occur: MUL is only entered when the output slot is free or draining at that edge.
- Back-pressure (`out_ready`=0) holds `valE`, `err`, `out_valid` and `cc`; `in_ready` falls.
- Reset asserted mid-MUL: `out_valid`=0 after that edge; the partial product is discarded.

## Structure
- Shared package `alu_pkg` holds:
  - op-code localparams ALU_ADD … ALU_MUL;
  - CC bit indices CC_ZF=2, CC_SF=1, CC_OF=0;
  - the state enum {S_IDLE, S_MUL};
  - CC_RESET = 3'b100.
- One sub-module, `alu_mul_iter`:
  - takes start, A, B; produces busy, done, a 2·WIDTH product and a count of width $clog2(WIDTH)+1;
  - `alu_pipe` owns the handshake, result/CC registers and the flag logic.

## Test plan
- Reset, WIDTH=64: hold `reset_n`=0 two cycles → `out_valid`=0, `valE`=0, `err`=0, `cc`=3'b100, `in_ready`=1 after release.
- ADD 0x7FFF_FFFF_FFFF_FFFF + 1 with `set_cc`=1 → `valE`=0x8000_0000_0000_0000 one edge later, `cc`=3'b011. Then SUB 5−5 with `set_cc`=0 → `valE`=0, `cc` unchanged at 3'b011.
- Back-to-back AND, XOR, ADD with `out_ready`=1 → three results on consecutive cycles, no bubbles. Then drop `out_ready` for 3 cycles → `valE` held, `in_ready`=0, and the offered op is not consumed.
- MUL 0x1_0000_0000 × 0x1_0000_0000 with `set_cc`=1 → `in_ready`=0 for 64 cycles, `out_valid` 64 edges after accept, `valE`=0, `cc`=3'b101. Also MUL 3×7 → 21, `cc`=3'b000.
- Illegal `alu_fun`=3'b110 with `set_cc`=1 → `valE`=0, `err`=1, `cc` unchanged.
- Reset asserted at iteration 30 of a MUL → after that edge `out_valid`=0, `cc`=3'b100. A following ADD 2+2 → 4 with normal latency.
